// File: rtl/gtfwizard_0_gtwiz_buffbypass_rx_if.sv
// rtl/gtfwizard_0_gtwiz_buffbypass_rx_if.sv - channel-side RX phase/delay alignment port bundle
interface gtfwizard_0_gtwiz_buffbypass_rx_if #(
    parameter int N = 1
);
    logic [N-1:0] rxphaligndone;
    logic [N-1:0] rxdlysresetdone;
    logic [N-1:0] rxsyncout;
    logic [N-1:0] rxsyncdone;
    logic [N-1:0] rxdlysreset;
    logic [N-1:0] rxsyncmode;
    logic [N-1:0] rxsyncallin;
    logic [N-1:0] rxsyncin;
    logic [N-1:0] rxphdlyreset;
    logic [N-1:0] rxphalign;
    logic [N-1:0] rxphalignen;
    logic [N-1:0] rxphdlypd;
    logic [N-1:0] rxphovrden;
    logic [N-1:0] rxdlybypass;
    logic [N-1:0] rxdlyen;
    logic [N-1:0] rxdlyovrden;

    modport master (
        input  rxphaligndone, rxdlysresetdone, rxsyncout, rxsyncdone,
        output rxdlysreset, rxsyncmode, rxsyncallin, rxsyncin,
               rxphdlyreset, rxphalign, rxphalignen, rxphdlypd,
               rxphovrden, rxdlybypass, rxdlyen, rxdlyovrden
    );

    modport slave (
        output rxphaligndone, rxdlysresetdone, rxsyncout, rxsyncdone,
        input  rxdlysreset, rxsyncmode, rxsyncallin, rxsyncin,
               rxphdlyreset, rxphalign, rxphalignen, rxphdlypd,
               rxphovrden, rxdlybypass, rxdlyen, rxdlyovrden
    );
endinterface

// File: rtl/gtfwizard_0_gtwiz_buffbypass_rx.sv
// rtl/gtfwizard_0_gtwiz_buffbypass_rx.sv - auto-mode RX buffer-bypass controller
// Define GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN to build the RXSYNCDONE watchdog with retries.
module gtfwizard_0_gtwiz_buffbypass_rx #(
    parameter int P_BUFFER_BYPASS_MODE       = 0,
    parameter int P_TOTAL_NUMBER_OF_CHANNELS = 1,
    parameter int P_MASTER_CHANNEL_POINTER   = 0,
    parameter int P_TIMEOUT_CYCLES           = 65536,
    parameter int P_MAX_RETRIES              = 3
) (
    input  logic gtwiz_buffbypass_rx_clk_in,
    input  logic gtwiz_buffbypass_rx_reset_n_in,
    input  logic gtwiz_buffbypass_rx_start_user_in,
    input  logic gtwiz_buffbypass_rx_resetdone_in,
    output logic gtwiz_buffbypass_rx_done_out,
    output logic gtwiz_buffbypass_rx_error_out,
    gtfwizard_0_gtwiz_buffbypass_rx_if.master ch
);
    localparam int N = P_TOTAL_NUMBER_OF_CHANNELS;
    localparam int M = P_MASTER_CHANNEL_POINTER;

    // Spare encodings are decoded as idle by the default branch.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEASSERT = 3'd1,
        S_WAIT     = 3'd2,
        S_DONE     = 3'd4
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = gtwiz_buffbypass_rx_clk_in;
    assign rst_n = gtwiz_buffbypass_rx_reset_n_in;

    assign ch.rxphdlyreset = '0;
    assign ch.rxphalign    = '0;
    assign ch.rxphalignen  = '0;
    assign ch.rxphdlypd    = '0;
    assign ch.rxphovrden   = '0;
    assign ch.rxdlybypass  = '0;
    assign ch.rxdlyen      = '0;
    assign ch.rxdlyovrden  = '0;

    if (P_BUFFER_BYPASS_MODE == 0) begin : g_auto
        logic [4:0] rd_meta;
        logic       rd_sync_d1;
        logic [3:0] sd_meta;
        logic       sd_sync_d1;
        logic [3:0] ph_meta;
        logic       sd_re;
        logic       start_int;
        state_t     state, state_nxt;
        logic       done_q, done_nxt;
        logic       error_q, error_nxt;
        logic       dlys_q, dlys_nxt;
        logic       timeout_fail;

        for (genvar i = 0; i < N; i++) begin : g_mode
            assign ch.rxsyncmode[i] = (i == M);
        end
        assign ch.rxsyncallin = {N{&ch.rxphaligndone}};
        assign ch.rxsyncin    = (N == 1) ? '0 : {N{ch.rxsyncout[M]}};
        assign ch.rxdlysreset = {N{dlys_q}};

        assign gtwiz_buffbypass_rx_done_out  = done_q;
        assign gtwiz_buffbypass_rx_error_out = error_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_meta    <= '0;
                rd_sync_d1 <= 1'b0;
                sd_meta    <= '0;
                sd_sync_d1 <= 1'b0;
                ph_meta    <= '0;
            end else begin
                rd_meta    <= {rd_meta[3:0], gtwiz_buffbypass_rx_resetdone_in};
                rd_sync_d1 <= rd_meta[4];
                sd_meta    <= {sd_meta[2:0], ch.rxsyncdone[M]};
                sd_sync_d1 <= sd_meta[3];
                ph_meta    <= {ph_meta[2:0], ch.rxphaligndone[M]};
            end
        end

        assign sd_re     = sd_meta[3] & ~sd_sync_d1;
        assign start_int = (rd_meta[4] & ~rd_sync_d1) | gtwiz_buffbypass_rx_start_user_in;

`ifdef GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN
        localparam int CW = $clog2(P_TIMEOUT_CYCLES + 1);
        localparam int RW = (P_MAX_RETRIES < 2) ? 1 : $clog2(P_MAX_RETRIES + 1);
        localparam logic [CW-1:0] TMO_LAST  = CW'(P_TIMEOUT_CYCLES - 1);
        localparam logic [RW-1:0] RETRY_MAX = RW'(P_MAX_RETRIES);
        logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
        logic [RW-1:0] retry_cnt, retry_cnt_nxt;
        logic          timeout_fail_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tmo_cnt      <= '0;
                retry_cnt    <= '0;
                timeout_fail <= 1'b0;
            end else begin
                tmo_cnt      <= tmo_cnt_nxt;
                retry_cnt    <= retry_cnt_nxt;
                timeout_fail <= timeout_fail_nxt;
            end
        end
`else
        assign timeout_fail = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                done_q  <= 1'b0;
                error_q <= 1'b0;
                dlys_q  <= 1'b0;
            end else begin
                state   <= state_nxt;
                done_q  <= done_nxt;
                error_q <= error_nxt;
                dlys_q  <= dlys_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            done_nxt  = done_q;
            error_nxt = error_q;
            dlys_nxt  = 1'b0;
`ifdef GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN
            tmo_cnt_nxt      = tmo_cnt;
            retry_cnt_nxt    = retry_cnt;
            timeout_fail_nxt = timeout_fail;
`endif
            case (state)
                S_DEASSERT: begin
                    state_nxt = S_WAIT;
`ifdef GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN
                    tmo_cnt_nxt = '0;
`endif
                end
                S_WAIT: begin
                    // A sync-done edge in the expiry cycle still counts as success.
                    if (sd_re) begin
                        state_nxt = S_DONE;
                    end
`ifdef GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt_nxt = retry_cnt + 1'b1;
                            dlys_nxt      = 1'b1;
                            state_nxt     = S_DEASSERT;
                        end else begin
                            timeout_fail_nxt = 1'b1;
                            state_nxt        = S_DONE;
                        end
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    done_nxt  = 1'b1;
                    error_nxt = ~ph_meta[3] | timeout_fail;
                    state_nxt = S_IDLE;
                end
                default: begin
                    if (start_int) begin
                        done_nxt  = 1'b0;
                        error_nxt = 1'b0;
                        dlys_nxt  = 1'b1;
                        state_nxt = S_DEASSERT;
`ifdef GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN
                        retry_cnt_nxt    = '0;
                        timeout_fail_nxt = 1'b0;
`endif
                    end
                end
            endcase
        end
    end else begin : g_none
        assign ch.rxsyncmode  = '0;
        assign ch.rxsyncallin = '0;
        assign ch.rxsyncin    = '0;
        assign ch.rxdlysreset = '0;
        assign gtwiz_buffbypass_rx_done_out  = 1'b0;
        assign gtwiz_buffbypass_rx_error_out = 1'b0;
    end
endmodule

// File: tb/tb_gtfwizard_0_gtwiz_buffbypass_rx.sv
// tb/tb_gtfwizard_0_gtwiz_buffbypass_rx.sv - bench for the RX buffer-bypass controller
// Timeout scenarios are built when GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_gtfwizard_0_gtwiz_buffbypass_rx;
    localparam int TMO_CYC   = 16;
    localparam int MAX_RETRY = 2;
    localparam int HL        = 8192;
`ifdef GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN
    localparam int T1_PULSES = 2;
`else
    localparam int T1_PULSES = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_user = 1'b0;
    logic resetdone = 1'b0;
    logic done1, err1, done4, err4;

    gtfwizard_0_gtwiz_buffbypass_rx_if #(.N(1)) ch1 ();
    gtfwizard_0_gtwiz_buffbypass_rx_if #(.N(4)) ch4 ();

    always #5 clk = ~clk;

    gtfwizard_0_gtwiz_buffbypass_rx #(
        .P_BUFFER_BYPASS_MODE(0), .P_TOTAL_NUMBER_OF_CHANNELS(1), .P_MASTER_CHANNEL_POINTER(0),
        .P_TIMEOUT_CYCLES(TMO_CYC), .P_MAX_RETRIES(MAX_RETRY)
    ) dut1 (
        .gtwiz_buffbypass_rx_clk_in(clk),
        .gtwiz_buffbypass_rx_reset_n_in(rst_n),
        .gtwiz_buffbypass_rx_start_user_in(start_user),
        .gtwiz_buffbypass_rx_resetdone_in(resetdone),
        .gtwiz_buffbypass_rx_done_out(done1),
        .gtwiz_buffbypass_rx_error_out(err1),
        .ch(ch1)
    );

    gtfwizard_0_gtwiz_buffbypass_rx #(
        .P_BUFFER_BYPASS_MODE(0), .P_TOTAL_NUMBER_OF_CHANNELS(4), .P_MASTER_CHANNEL_POINTER(2),
        .P_TIMEOUT_CYCLES(TMO_CYC), .P_MAX_RETRIES(MAX_RETRY)
    ) dut4 (
        .gtwiz_buffbypass_rx_clk_in(clk),
        .gtwiz_buffbypass_rx_reset_n_in(rst_n),
        .gtwiz_buffbypass_rx_start_user_in(1'b0),
        .gtwiz_buffbypass_rx_resetdone_in(1'b0),
        .gtwiz_buffbypass_rx_done_out(done4),
        .gtwiz_buffbypass_rx_error_out(err4),
        .ch(ch4)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_q[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timing-rule model: input histories per cycle, outputs scheduled as events.
    bit hist [3][HL];
    int last_rst = 0;
    bit busy = 0;
    int wait_from = -1;
    int fin_at = -1;
    bit fin_err = 0;
    int retries = 0;
    bit e_pulse = 0, e_done = 0, e_err = 0;

    function automatic bit past(input int s, input int k);
        return (k > last_rst && k >= 0 && k < HL) ? hist[s][k] : 1'b0;
    endfunction

    always @(negedge clk) begin
        bit s_int, s_re, n_pulse, n_done, n_err;
        if (cyc < HL) begin
            hist[0][cyc] = resetdone;
            hist[1][cyc] = ch1.rxsyncdone[0];
            hist[2][cyc] = ch1.rxphaligndone[0];
        end
        if (!rst_n) begin
            last_rst = cyc;
            e_pulse = 0; e_done = 0; e_err = 0;
        end
        chk("dlysreset1", 4'(ch1.rxdlysreset), 4'(e_pulse));
        chk("done1", 4'(done1), 4'(e_done));
        chk("error1", 4'(err1), 4'(e_err));
        chk("syncmode1", 4'(ch1.rxsyncmode), 4'h1);
        chk("syncallin1", 4'(ch1.rxsyncallin), 4'(ch1.rxphaligndone));
        chk("syncin1", 4'(ch1.rxsyncin), 4'h0);
        chk("zeros1", 4'(ch1.rxphdlyreset | ch1.rxphalign | ch1.rxphalignen | ch1.rxphdlypd |
                         ch1.rxphovrden | ch1.rxdlybypass | ch1.rxdlyen | ch1.rxdlyovrden), 4'h0);
        chk("syncmode4", ch4.rxsyncmode, 4'b0100);
        chk("syncallin4", ch4.rxsyncallin, (ch4.rxphaligndone == 4'hF) ? 4'hF : 4'h0);
        chk("syncin4", ch4.rxsyncin, ch4.rxsyncout[2] ? 4'hF : 4'h0);
        chk("zeros4", ch4.rxphdlyreset | ch4.rxphalign | ch4.rxphalignen | ch4.rxphdlypd |
                      ch4.rxphovrden | ch4.rxdlybypass | ch4.rxdlyen | ch4.rxdlyovrden |
                      ch4.rxdlysreset, 4'h0);
        chk("idle4", {2'b00, done4, err4}, 4'h0);
        if (rst_n && ch1.rxdlysreset[0]) begin
            pulse_cnt++;
            pulse_q.push_back(cyc);
        end

        s_int   = (past(0, cyc - 5) && !past(0, cyc - 6)) || start_user;
        s_re    = past(1, cyc - 4) && !past(1, cyc - 5);
        n_pulse = 0;
        n_done  = e_done;
        n_err   = e_err;
        if (!rst_n) begin
            busy = 0; wait_from = -1; fin_at = -1;
            n_done = 0; n_err = 0;
        end else begin
            if (!busy) begin
                if (s_int) begin
                    busy = 1; n_pulse = 1; n_done = 0; n_err = 0;
                    wait_from = cyc + 2; retries = 0;
                end
            end else if (wait_from >= 0 && cyc >= wait_from) begin
                if (s_re) begin
                    fin_at = cyc + 2; fin_err = !past(2, cyc - 3); wait_from = -1;
                end
`ifdef GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN
                else if (cyc == wait_from + TMO_CYC - 1) begin
                    if (retries < MAX_RETRY) begin
                        retries++; n_pulse = 1; wait_from = cyc + 2;
                    end else begin
                        fin_at = cyc + 2; fin_err = 1; wait_from = -1;
                    end
                end
`endif
            end
            if (fin_at == cyc + 1) begin
                n_done = 1; n_err = fin_err; busy = 0; fin_at = -1;
            end
        end
        e_pulse = n_pulse; e_done = n_done; e_err = n_err;
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start_user = 1'b1;
        tick(1);
        start_user = 1'b0;
    endtask

    initial begin
        int p0;
        ch1.rxphaligndone = '0; ch1.rxdlysresetdone = '0; ch1.rxsyncout = '0; ch1.rxsyncdone = '0;
        ch4.rxphaligndone = '0; ch4.rxdlysresetdone = '0; ch4.rxsyncout = '0; ch4.rxsyncdone = '0;

        tick(3);
        sample;
        chk("rst_done", 4'(done1), 4'h0);
        chk("rst_dlys", 4'(ch1.rxdlysreset), 4'h0);
        rst_n = 1'b1;

        // Procedure triggered by the reset-done edge, with phase alignment good.
        ch1.rxphaligndone = 1'b1;
        tick(2);
        p0 = pulse_cnt;
        resetdone = 1'b1;
        tick(20);
        ch1.rxsyncdone = 1'b1;
        tick(7);
        sample;
        chk("t1_done", 4'(done1), 4'h1);
        chk("t1_error", 4'(err1), 4'h0);
        chk("t1_pulses", 4'(pulse_cnt - p0), 4'(T1_PULSES));

        // Multi-lane tie-offs.
        ch4.rxphaligndone = 4'b1011;
        ch4.rxsyncout = 4'b1011;
        tick(1);
        sample;
        chk("t2_allin_part", ch4.rxsyncallin, 4'h0);
        chk("t2_syncin_lo", ch4.rxsyncin, 4'h0);
        ch4.rxphaligndone = 4'b1111;
        ch4.rxsyncout = 4'b0100;
        tick(1);
        sample;
        chk("t2_allin_full", ch4.rxsyncallin, 4'hF);
        chk("t2_syncin_hi", ch4.rxsyncin, 4'hF);
        chk("t2_mode", ch4.rxsyncmode, 4'b0100);

        // Sync done while phase alignment is low gives an error.
        tick(1);
        ch1.rxsyncdone = 1'b0;
        ch1.rxphaligndone = 1'b0;
        tick(2);
        pulse_start;
        sample;
        chk("t3_clr_done", 4'(done1), 4'h0);
        chk("t3_pulse", 4'(ch1.rxdlysreset), 4'h1);
        tick(3);
        ch1.rxsyncdone = 1'b1;
        tick(7);
        sample;
        chk("t3_done", 4'(done1), 4'h1);
        chk("t3_error", 4'(err1), 4'h1);

        // User restart clears the sticky flags the next cycle.
        ch1.rxsyncdone = 1'b0;
        ch1.rxphaligndone = 1'b1;
        tick(2);
        pulse_start;
        sample;
        chk("t3b_done", 4'(done1), 4'h0);
        chk("t3b_error", 4'(err1), 4'h0);
        chk("t3b_pulse", 4'(ch1.rxdlysreset), 4'h1);

        // Reset while waiting, then the stale sync-done edge must be ignored.
        tick(2);
        ch1.rxsyncdone = 1'b1;
        tick(2);
        rst_n = 1'b0;
        resetdone = 1'b0;
        sample;
        chk("t4_rst_done", 4'(done1), 4'h0);
        chk("t4_rst_dlys", 4'(ch1.rxdlysreset), 4'h0);
        tick(3);
        rst_n = 1'b1;
        tick(12);
        sample;
        chk("t4_stale_done", 4'(done1), 4'h0);
        chk("t4_stale_err", 4'(err1), 4'h0);

`ifdef GTWIZ_BUFFBYPASS_RX_TIMEOUT_EN
        // Watchdog: two retries then failure.
        ch1.rxsyncdone = 1'b0;
        tick(2);
        p0 = pulse_cnt;
        pulse_start;
        tick(60);
        sample;
        chk("t5_pulses", 4'(pulse_cnt - p0), 4'h3);
        chk("t5_gap_a", 4'(pulse_q[pulse_q.size()-2] - pulse_q[pulse_q.size()-3]), 4'(17));
        chk("t5_gap_b", 4'(pulse_q[pulse_q.size()-1] - pulse_q[pulse_q.size()-2]), 4'(17));
        chk("t5_done", 4'(done1), 4'h1);
        chk("t5_error", 4'(err1), 4'h1);

        // Sync-done edge lands in the expiry cycle: success, no retry.
        tick(2);
        p0 = pulse_cnt;
        pulse_start;
        tick(12);
        ch1.rxsyncdone = 1'b1;
        tick(7);
        sample;
        chk("t6_pulses", 4'(pulse_cnt - p0), 4'h1);
        chk("t6_done", 4'(done1), 4'h1);
        chk("t6_error", 4'(err1), 4'h0);
`endif

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
